// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared constants for the modulus up/down counter.
//   GO_UP / GO_DOWN      : {Up,Down} direction encodings that request a count
//   MODE_WRAP / MODE_SAT : overflow handling selected by SatMode
//   isCountDir()         : true when a {Up,Down} pair requests a count
// -----------------------------------------------------------------------------
package mod_counter_pkg;

    localparam logic [1:0] GO_UP   = 2'b10;
    localparam logic [1:0] GO_DOWN = 2'b01;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // 2'b00 and 2'b11 both decode to hold.
    function automatic logic isCountDir(input logic [1:0] dir);
        return (dir == GO_UP) || (dir == GO_DOWN);
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// -----------------------------------------------------------------------------
// mod_counter_next
// Purely combinational next-count computation for mod_updown_counter.
// Ports:
//   Count       in  BITS  current registered count
//   Limit       in  BITS  inclusive terminal value (range 0..Limit)
//   S           in  BITS  effective step, already clamped to Limit
//   StepNonZero in  1     raw Step input was non-zero (needed when Limit = 0,
//                         where S is forced to 0 but events must still fire)
//   Direction   in  2     {Up,Down}; only GO_UP / GO_DOWN change the count
//   SatMode     in  1     MODE_WRAP or MODE_SAT
//   NextCount   out BITS  count to load on a count cycle
//   Carry       out 1     up-overflow event for this count cycle
//   Borrow      out 1     down-underflow event for this count cycle
// -----------------------------------------------------------------------------
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] Count,
    input  logic [BITS-1:0] Limit,
    input  logic [BITS-1:0] S,
    input  logic            StepNonZero,
    input  logic [1:0]      Direction,
    input  logic            SatMode,
    output logic [BITS-1:0] NextCount,
    output logic            Carry,
    output logic            Borrow
);

    localparam logic [BITS:0] ONE_EXT = {{BITS{1'b0}}, 1'b1};

    // One extra bit keeps Count+S and Count+Limit+1 from truncating.
    logic [BITS:0] cntExt;
    logic [BITS:0] limExt;
    logic [BITS:0] sExt;
    logic [BITS:0] upSum;
    logic [BITS:0] upWrap;
    logic [BITS:0] downDiff;
    logic [BITS:0] downWrap;

    assign cntExt   = {1'b0, Count};
    assign limExt   = {1'b0, Limit};
    assign sExt     = {1'b0, S};
    assign upSum    = cntExt + sExt;
    assign upWrap   = upSum - (limExt + ONE_EXT);
    assign downDiff = cntExt - sExt;
    assign downWrap = cntExt + (limExt + ONE_EXT) - sExt;

    // NOTE: every output gets a default before the if/else chain, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        NextCount = Count;
        Carry     = 1'b0;
        Borrow    = 1'b0;

        if (cntExt > limExt) begin
            // Limit was lowered below the count: snap back, no event.
            NextCount = Limit;
        end else if (Direction == GO_UP) begin
            if (Limit == '0) begin
                Carry = StepNonZero;
            end else if (upSum > limExt) begin
                Carry     = 1'b1;
                NextCount = (SatMode == MODE_SAT) ? Limit : upWrap[BITS-1:0];
            end else begin
                NextCount = upSum[BITS-1:0];
            end
        end else if (Direction == GO_DOWN) begin
            if (Limit == '0) begin
                Borrow = StepNonZero;
            end else if (cntExt < sExt) begin
                Borrow    = 1'b1;
                NextCount = (SatMode == MODE_SAT) ? '0 : downWrap[BITS-1:0];
            end else begin
                NextCount = downDiff[BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
// Up/down counter with run-time modulus (0..Limit), programmable step,
// wrap/saturate overflow and registered carry/borrow pulses for cascading.
// Optional feature macro: MOD_COUNTER_LOAD_EN adds Load/LoadValue, a
// synchronous load with highest priority that is independent of Enable.
// Ports:
//   Clock       in  1          rising-edge clock
//   ResetN      in  1          asynchronous active-low reset
//   Enable      in  1          count-cycle qualifier
//   Up, Down    in  1          direction request; 10 up, 01 down, else hold
//   SatMode     in  1          0 = wrap, 1 = saturate
//   Limit       in  BITS       inclusive terminal value
//   Step        in  STEP_BITS  step magnitude (clamped to Limit)
//   Load        in  1          synchronous load     (MOD_COUNTER_LOAD_EN only)
//   LoadValue   in  BITS       load data            (MOD_COUNTER_LOAD_EN only)
//   Count       out BITS       registered count
//   FullFlag    out 1          Count == Limit
//   EmptyFlag   out 1          Count == 0
//   CarryPulse  out 1          registered one-cycle up-overflow event
//   BorrowPulse out 1          registered one-cycle down-underflow event
// -----------------------------------------------------------------------------
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int STEP_BITS = 4
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Enable,
    input  logic                 Up,
    input  logic                 Down,
    input  logic                 SatMode,
    input  logic [BITS-1:0]      Limit,
    input  logic [STEP_BITS-1:0] Step,
`ifdef MOD_COUNTER_LOAD_EN
    input  logic                 Load,
    input  logic [BITS-1:0]      LoadValue,
`endif
    output logic [BITS-1:0]      Count,
    output logic                 FullFlag,
    output logic                 EmptyFlag,
    output logic                 CarryPulse,
    output logic                 BorrowPulse
);

    logic [1:0]      direction;
    logic            countCycle;
    logic [BITS-1:0] stepExt;
    logic [BITS-1:0] stepEff;
    logic [BITS-1:0] nextCount;
    logic            nextCarry;
    logic            nextBorrow;

    assign direction  = {Up, Down};
    assign countCycle = Enable && isCountDir(direction);
    assign stepExt    = BITS'(Step);
    assign stepEff    = (stepExt > Limit) ? Limit : stepExt;

    mod_counter_next #(
        .BITS(BITS)
    ) u_next (
        .Count      (Count),
        .Limit      (Limit),
        .S          (stepEff),
        .StepNonZero(Step != '0),
        .Direction  (direction),
        .SatMode    (SatMode),
        .NextCount  (nextCount),
        .Carry      (nextCarry),
        .Borrow     (nextBorrow)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Count       <= '0;
            CarryPulse  <= 1'b0;
            BorrowPulse <= 1'b0;
        end else begin
`ifdef MOD_COUNTER_LOAD_EN
            if (Load) begin
                Count       <= (LoadValue > Limit) ? Limit : LoadValue;
                CarryPulse  <= 1'b0;
                BorrowPulse <= 1'b0;
            end else
`endif
            if (countCycle) begin
                Count       <= nextCount;
                CarryPulse  <= nextCarry;
                BorrowPulse <= nextBorrow;
            end else begin
                CarryPulse  <= 1'b0;
                BorrowPulse <= 1'b0;
            end
        end
    end

    // Flags track Limit combinationally, so a Limit change shows immediately.
    assign FullFlag  = (Count == Limit);
    assign EmptyFlag = (Count == '0);

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parameterised up/down counter with a run-time modulus, programmable step, and a wrap or saturate overflow mode. It generalises the basic up/down counter. It also registers carry/borrow event pulses so counters can be cascaded, or can drive timers and pointer logic elsewhere in the design. It is a single-clock block with an asynchronous active-low reset.

## Interface
- BITS, 8, counter width; legal range 2..32
- STEP_BITS, 4, width of the Step input; must be ≤ BITS
- Clock  input  1  rising-edge clock
- ResetN  input  1  asynchronous, active-low reset; deassertion is synchronous to Clock externally
- Enable  input  1  count-cycle qualifier
- Up  input  1  count-up request
- Down  input  1  count-down request
- SatMode  input  1  overflow mode: 0 = wrap, 1 = saturate
- Limit  input  BITS  inclusive terminal value; count range is 0..Limit
- Step  input  STEP_BITS  increment/decrement magnitude
- Load  input  1  synchronous load (present only with MOD_COUNTER_LOAD_EN)
- LoadValue  input  BITS  load data (present only with MOD_COUNTER_LOAD_EN)
- Count  output  BITS  registered count
- FullFlag  output  1  Count == Limit (combinational from registers/inputs)
- EmptyFlag  output  1  Count == 0
- CarryPulse  output  1  registered, one-cycle up-overflow event
- BorrowPulse  output  1  registered, one-cycle down-underflow event

## Operation
- Direction decode is {Up,Down}: 2'b10 counts up, 2'b01 counts down, 2'b00 and 2'b11 hold.
- Effective step: S = min(zero-extended Step, Limit). Step = 0 holds the count but is still a count cycle.
- All arithmetic is done in BITS+1 bits. No intermediate result may truncate.
- Up, Count+S ≤ Limit: Count ← Count+S.
- Up, Count+S > Limit:
  - wrap mode: Count ← Count+S−(Limit+1)
  - saturate mode: Count ← Limit
  - CarryPulse ← 1 in both modes.
- Down, Count ≥ S: Count ← Count−S.
- Down, Count < S:
  - wrap mode: Count ← Count+(Limit+1)−S
  - saturate mode: Count ← 0
  - BorrowPulse ← 1 in both modes.
- Limit = 0: Count stays 0. A count cycle with Step ≠ 0 still pulses Carry or Borrow as above.
- Count > Limit at a count cycle (Limit lowered at run time): Count ← Limit, regardless of direction and mode. No pulse.
- Enable = 0 or hold decode: Count holds; both pulses ← 0.
- Load (macro builds only) has highest priority and is independent of Enable.
  - Count ← LoadValue, clamped to Limit if LoadValue > Limit.
  - Both pulses ← 0.
- There is no state machine beyond the Count register and the two pulse registers.

## Timing
- Reset values: Count = 0, CarryPulse = 0, BorrowPulse = 0. Hence EmptyFlag = 1, and FullFlag = (Limit == 0).
- Reset asserted mid-count clears Count and both pulses immediately, with no clock required.
- Count latency: one cycle. The update happens on the rising edge where the command is sampled.
- CarryPulse and BorrowPulse are high for exactly the cycle after the overflowing edge, i.e. coincident with the new Count.
- Back-to-back overflow cycles keep the pulse high continuously.
- Flags follow Count and Limit combinationally. A change on Limit is reflected on FullFlag in the same cycle.

## Configuration
- MOD_COUNTER_LOAD_EN defined: the Load and LoadValue ports and the load path exist, as described under Operation.
- MOD_COUNTER_LOAD_EN undefined: both ports are absent and Count changes only by reset and count cycles.

## Structure
- mod_counter_pkg holds:
  - the direction encodings GO_UP = 2'b10 and GO_DOWN = 2'b01
  - the mode constants MODE_WRAP = 1'b0 and MODE_SAT = 1'b1
- Sub-module mod_counter_next: purely combinational next-count and overflow/underflow computation (inputs Count, Limit, S, direction, mode). The top module holds only the registers, the load mux and the flags.

## Test plan
- Reset, BITS=4, Limit=9: assert ResetN=0 mid-count at Count=5 → Count=0, EmptyFlag=1, pulses 0, with no clock edge needed.
- Wrap up: Limit=9, Step=3, Up, Count=8 → next Count=1, CarryPulse=1 for one cycle; following cycle Count=4, CarryPulse=0.
- Saturate down: SatMode=1, Limit=9, Step=4, Down, Count=2 → Count=0, BorrowPulse=1; next cycle Count stays 0, BorrowPulse stays 1.
- Simultaneous Up=Down=1, and Enable=0 with Up=1: Count=7 → Count stays 7 and pulses stay 0, in both cases.
- Limit lowered: Count=12, Limit changed from 15 to 9, Up with Step=1 → Count=9, FullFlag=1, no CarryPulse.
- Load (macro on): Limit=9, LoadValue=14, Load=1, Enable=0 → Count=9; with LoadValue=3 and Up asserted simultaneously → Count=3.
